// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
//
// Purpose:
//   Table of 2-bit branch direction counters indexed by PC bits
//   [IDX_W+1:2]. A lookup returns the stored counter one cycle later. A
//   resolved-branch update rewrites its entry in a single edge
//   (read-modify-write).
//
//   Counter encoding: ST=00, T=01, NT=10, SNT=11. ST and T predict taken.
//   Next state (taken / not-taken):
//     ST:  ST/T
//     T:   ST/SNT
//     NT:  ST/SNT
//     SNT: NT/SNT
//
// Optional feature:
//   Define BHT_GSHARE_EN to enable gshare indexing.
//   - An IDX_W-bit global history register (GHR) shifts in upd_taken on
//     every update.
//   - The lookup index is the base index XOR the GHR.
//   - The update index is the base index XOR upd_ghr.
//   Without the macro there is no GHR, pred_ghr is tied to 0 and upd_ghr is
//   unused.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-high reset
//   lookup_valid  in   prediction request
//   lookup_pc     in   PC of the branch being predicted
//   pred_valid    out  prediction result valid (1 cycle after lookup)
//   pred_state    out  counter value read for the lookup
//   pred_taken    out  predicted direction
//   pred_ghr      out  history snapshot used by the lookup
//   upd_valid     in   resolved-branch update
//   upd_pc        in   PC of the resolved branch
//   upd_taken     in   actual outcome
//   upd_ghr       in   pred_ghr returned with the resolved branch
// ---------------------------------------------------------------------------
module branch_history_table #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int PC_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_valid,
    output logic [1:0]       pred_state,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [IDX_W-1:0] upd_ghr
);

    localparam logic [1:0] ST  = 2'b00;
    localparam logic [1:0] T   = 2'b01;
    localparam logic [1:0] NT  = 2'b10;
    localparam logic [1:0] SNT = 2'b11;

    function automatic logic [1:0] next_state(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        case (cur)
            ST:      nxt = taken ? ST : T;
            T:       nxt = taken ? ST : SNT;
            NT:      nxt = taken ? ST : SNT;
            default: nxt = taken ? NT : SNT;
        endcase
        return nxt;
    endfunction

    logic [1:0]       bht_q [ENTRIES];
    logic [IDX_W-1:0] lookup_base;
    logic [IDX_W-1:0] upd_base;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_state_d;

    logic             pred_valid_q;
    logic [1:0]       pred_state_q;
    logic [1:0]       pred_state_d;

    assign lookup_base = lookup_pc[IDX_W+1:2];
    assign upd_base    = upd_pc[IDX_W+1:2];

    // Only PC bits [IDX_W+1:2] select an entry; the rest are deliberately dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;
    logic [IDX_W-1:0] pred_ghr_q;
    logic [IDX_W-1:0] pred_ghr_d;

    assign lookup_idx = lookup_base ^ ghr_q;
    assign upd_idx    = upd_base ^ upd_ghr;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ghr_d      = ghr_q;
        pred_ghr_d = pred_ghr_q;
        if (upd_valid) begin
            ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
        end
        if (lookup_valid) begin
            pred_ghr_d = ghr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q      <= '0;
            pred_ghr_q <= '0;
        end else begin
            ghr_q      <= ghr_d;
            pred_ghr_q <= pred_ghr_d;
        end
    end

    assign pred_ghr = pred_ghr_q;
`else
    logic unused_upd_ghr;
    assign unused_upd_ghr = ^upd_ghr;

    assign lookup_idx = lookup_base;
    assign upd_idx    = upd_base;
    assign pred_ghr   = '0;
`endif

    always_comb begin
        upd_state_d  = next_state(bht_q[upd_idx], upd_taken);
        pred_state_d = pred_state_q;
        if (lookup_valid) begin
            pred_state_d = bht_q[lookup_idx];
        end
    end

    // NOTE: the counter array is reset because every entry must read NT
    // straight out of reset. This costs per-entry reset flops rather than a
    // RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= NT;
            end
        end else if (upd_valid) begin
            bht_q[upd_idx] <= upd_state_d;
        end
    end

    // NOTE: non-blocking assignments mean a lookup that collides with an
    // update on the same edge sees the pre-update counter, while the write
    // still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_state_q <= NT;
        end else begin
            pred_valid_q <= lookup_valid;
            pred_state_q <= pred_state_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_state = pred_state_q;
    assign pred_taken = ~pred_state_q[1];

endmodule

// File: tb/tb_branch_history_table.sv
// ---------------------------------------------------------------------------
// tb_branch_history_table
//
// Directed bench for branch_history_table (ENTRIES=64, IDX_W=6, PC_W=32).
//
// A behavioural model tracks the table as an integer array:
//   - the index is (pc / 4) mod 64, XOR the history when gshare is built in;
//   - counter transitions come from a 4x2 lookup table.
// The model holds the expected registered outputs, and a negedge process
// compares them with the DUT every cycle. Directed sequences also check
// hand-computed literal values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_history_table;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;
    localparam int PC_W    = 32;

    logic             clk;
    logic             rst;
    logic             lookup_valid;
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_valid;
    logic [1:0]       pred_state;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic [IDX_W-1:0] upd_ghr;

    branch_history_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .pred_valid   (pred_valid),
        .pred_state   (pred_state),
        .pred_taken   (pred_taken),
        .pred_ghr     (pred_ghr),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_ghr      (upd_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States 0..3 = ST, T, NT, SNT. Row = state, column = {not-taken, taken}.
    int nxt_tbl [4][2] = '{'{1, 0}, '{3, 0}, '{3, 0}, '{3, 2}};
    int m_bht [ENTRIES];
    int m_ghr;
    bit gshare;
    bit exp_valid;
    int exp_state;
    int exp_ghr;

    function automatic int model_idx(input logic [PC_W-1:0] pc, input int hist);
        int base;
        base = int'((pc / 4) % ENTRIES);
        return gshare ? (base ^ hist) : base;
    endfunction

    task automatic model_reset();
        foreach (m_bht[i]) m_bht[i] = 2;
        m_ghr     = 0;
        exp_valid = 1'b0;
        exp_state = 2;
        exp_ghr   = 0;
    endtask

    // One clock: drive inputs, advance the model across the edge, return #1 after it.
    task automatic cycle(input logic lv, input logic [PC_W-1:0] lpc,
                         input logic uv, input logic [PC_W-1:0] upc,
                         input logic ut, input logic [IDX_W-1:0] ughr);
        int  li, ui, n_state, n_ghr;
        bit  n_valid;
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_taken    = ut;
        upd_ghr      = ughr;
        li      = model_idx(lpc, m_ghr);
        ui      = model_idx(upc, int'(ughr));
        n_valid = lv;
        n_state = lv ? m_bht[li] : exp_state;
        n_ghr   = lv ? (gshare ? m_ghr : 0) : exp_ghr;
        @(posedge clk);
        if (uv) begin
            m_bht[ui] = nxt_tbl[m_bht[ui]][ut ? 1 : 0];
            if (gshare) m_ghr = ((m_ghr << 1) | (ut ? 1 : 0)) % ENTRIES;
        end
        exp_valid = n_valid;
        exp_state = n_state;
        exp_ghr   = n_ghr;
        #1;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc);
        cycle(1'b1, pc, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic update(input logic [PC_W-1:0] pc, input logic t, input logic [IDX_W-1:0] g);
        cycle(1'b0, '0, 1'b1, pc, t, g);
    endtask

    // Reset asserted away from the clock edge; outputs must change without an edge.
    // Lookups and updates are presented during reset and must be ignored.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_pred_valid", {31'b0, pred_valid}, 32'd0);
        check("async_rst_pred_state", {30'b0, pred_state}, 32'd2);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        upd_valid    = 1'b1;
        upd_pc       = 32'h40;
        upd_taken    = 1'b1;
        upd_ghr      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("pred_valid", {31'b0, pred_valid}, {31'b0, exp_valid});
                check("pred_state", {30'b0, pred_state}, exp_state);
                check("pred_taken", {31'b0, pred_taken}, (exp_state < 2) ? 32'd1 : 32'd0);
                check("pred_ghr",   {26'b0, pred_ghr},   exp_ghr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BHT_GSHARE_EN
        gshare = 1'b1;
`else
        gshare = 1'b0;
`endif
        rst = 1'b1;
        lookup_valid = 1'b0; lookup_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_ghr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;

        // Reset state: any PC reads NT.
        lookup(32'h40);
        check("reset_lookup_state", {30'b0, pred_state}, 32'd2);
        check("reset_lookup_taken", {31'b0, pred_taken}, 32'd0);

`ifndef BHT_GSHARE_EN
        // Transition sequence on 0x40: T,T,N,N,N -> ST,ST,T,SNT,SNT.
        begin
            logic [4:0] outc;
            int         want [5];
            outc = 5'b00011;
            want = '{0, 0, 1, 3, 3};
            for (int i = 0; i < 5; i++) begin
                update(32'h40, outc[i], '0);
                lookup(32'h40);
                check("table_seq_state", {30'b0, pred_state}, want[i]);
            end
        end

        // Saturation from SNT: taken -> NT, taken -> ST, taken -> ST.
        update(32'h40, 1'b1, '0);
        lookup(32'h40);
        check("snt_taken_to_nt", {30'b0, pred_state}, 32'd2);

        // Collision from NT: lookup sees the pre-update value, the write lands.
        do_reset();
        cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, '0);
        check("collision_pre_update", {30'b0, pred_state}, 32'd2);
        lookup(32'h40);
        check("collision_after_write", {30'b0, pred_state}, 32'd0);

        // Aliasing: 0x140 shares the entry of 0x40.
        do_reset();
        update(32'h40, 1'b1, '0);
        lookup(32'h140);
        check("alias_0x140", {30'b0, pred_state}, 32'd0);
        lookup(32'hFFFF_FF40);
        check("alias_high_bits", {30'b0, pred_state}, 32'd0);

        // Back-to-back updates to one index accumulate: NT -N-> SNT -T-> NT.
        update(32'h80, 1'b0, 6'h3F);
        update(32'h80, 1'b1, 6'h15);
        lookup(32'h80);
        check("back_to_back", {30'b0, pred_state}, 32'd2);
`else
        // gshare: two taken updates build history 000011.
        do_reset();
        update(32'h0, 1'b1, 6'h00);
        update(32'h0, 1'b1, 6'h00);
        lookup(32'h40);
        check("gshare_pred_ghr", {26'b0, pred_ghr}, 32'h03);
        check("gshare_lookup_nt", {30'b0, pred_state}, 32'd2);
        // Update entry 0x10^0x03 = 0x13; GHR becomes 000111.
        update(32'h40, 1'b1, 6'h03);
        lookup(32'h50);   // base 0x14 ^ 0x07 = 0x13
        check("gshare_entry13", {30'b0, pred_state}, 32'd0);
        lookup(32'h5C);   // base 0x17 ^ 0x07 = 0x10, untouched
        check("gshare_entry10", {30'b0, pred_state}, 32'd2);
`endif

        // pred_valid timing: one-cycle pulse, then held outputs while idle.
        lookup(32'h44);
        check("pulse_valid_hi", {31'b0, pred_valid}, 32'd1);
        cycle(1'b0, 32'h40, 1'b0, '0, 1'b0, '0);
        check("pulse_valid_lo", {31'b0, pred_valid}, 32'd0);
        cycle(1'b0, '0, 1'b1, 32'h44, 1'b1, '0);

        // Mixed directed traffic checked by the model.
        begin
            logic [PC_W-1:0] pcs [8];
            pcs = '{32'h0, 32'h4, 32'h40, 32'h140, 32'hFC, 32'h1234, 32'h80, 32'h40};
            for (int i = 0; i < 24; i++) begin
                cycle(i % 3 != 2, pcs[i % 8], i % 2 == 0, pcs[(i + 3) % 8],
                      (i % 5) < 3, IDX_W'(i));
            end
        end

        // Mid-run reset, then a lookup on the first edge after release.
        do_reset();
        lookup(32'h1234);
        check("post_reset_state", {30'b0, pred_state}, 32'd2);
        check("post_reset_taken", {31'b0, pred_taken}, 32'd0);
        check("post_reset_valid", {31'b0, pred_valid}, 32'd1);

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of 2-bit counter entries (power of two, at least 4).
REQ-002 SHALL have parameter IDX_W, default 6, log2(ENTRIES), index width.
REQ-003 SHALL have parameter PC_W, default 32, program-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port lookup_valid  input  1  fetch-stage prediction request.
REQ-007 SHALL have port lookup_pc  input  PC_W  PC of the branch being predicted.
REQ-008 SHALL have port pred_valid  output  1  prediction result valid.
REQ-009 SHALL have port pred_state  output  2  counter read for the lookup (CS_read to the predictor).
REQ-010 SHALL have port pred_taken  output  1  predicted direction.
REQ-011 SHALL have port pred_ghr  output  IDX_W  history snapshot used by the lookup.
REQ-012 SHALL have port upd_valid  input  1  resolved-branch update from execute.
REQ-013 SHALL have port upd_pc  input  PC_W  PC of the resolved branch.
REQ-014 SHALL have port upd_taken  input  1  actual outcome.
REQ-015 SHALL have port upd_ghr  input  IDX_W  pred_ghr value returned with the resolved branch.

Function
REQ-016 SHALL encode counters as ST=00, T=01, NT=10, SNT=11.
REQ-017 SHALL predict taken for ST and T, and not-taken for NT and SNT.
REQ-018 SHALL use the following next-state table, as (state, taken/not-taken) -> next state: ST: ST/T; T: ST/SNT; NT: ST/SNT; SNT: NT/SNT.
REQ-019 SHALL form the base index as pc[IDX_W+1:2].
REQ-020 SHALL, on a rising edge with lookup_valid=1, register pred_valid=1 together with pred_state, pred_taken and pred_ghr for the lookup index (latency 1 cycle).
REQ-021 SHALL, on a rising edge with lookup_valid=0, register pred_valid=0; pred_state, pred_taken and pred_ghr then hold their previous values.
REQ-022 SHALL, on a rising edge with upd_valid=1, write entry[update index] with its next state per REQ-018 from the stored value (single-edge read-modify-write).
REQ-023 SHALL, when a lookup and an update hit the same index on the same edge, return the pre-update value to the lookup; the write still occurs.
REQ-024 SHALL apply back-to-back updates to one index cumulatively, each update seeing the previous write.
REQ-025 SHALL keep entries at their ST and SNT endpoints (saturation) per REQ-018 with no wrap.
REQ-026 SHALL ignore PC bits outside [IDX_W+1:2]; aliasing PCs share one entry.

Reset
REQ-027 SHALL, while rst=1, immediately force every entry to NT, pred_valid=0, pred_state=NT, pred_taken=0, pred_ghr=0 and the GHR to 0.
REQ-028 SHALL ignore lookups and updates while rst=1; a lookup on the first edge after deassertion is serviced normally.

Configuration
REQ-029 SHALL, with macro BHT_GSHARE_EN defined, maintain an IDX_W-bit GHR updated on each upd_valid edge as {ghr[IDX_W-2:0], upd_taken}.
REQ-030 SHALL, with BHT_GSHARE_EN defined, use lookup index = base index XOR current GHR, update index = base index XOR upd_ghr, and pred_ghr = GHR at lookup.
REQ-031 SHALL, without BHT_GSHARE_EN, omit the GHR, use base indices directly, drive pred_ghr=0 and ignore upd_ghr.

Verification
REQ-032 SHALL cover reset: assert rst mid-run -> lookup of any PC after release gives pred_state=10, pred_taken=0.
REQ-033 SHALL cover the transition table: updates taken,taken,not,not,not to PC 0x40 -> states ST, ST, T, SNT, SNT; lookups confirm each.
REQ-034 SHALL cover the same-index collision: lookup and update (taken) of 0x40 on one edge from NT -> pred_state=10, next lookup gives 00.
REQ-035 SHALL cover aliasing: update 0x40 taken, then look up 0x140 (ENTRIES=64) -> pred_state=00.
REQ-036 SHALL cover gshare with BHT_GSHARE_EN: after updates taken,taken from reset, lookup 0x40 -> pred_ghr=000011, index 0x13; update with upd_ghr=000011 modifies entry 0x13 only.
REQ-037 SHALL cover pred_valid timing: a lookup_valid pulse of 1 cycle -> pred_valid high exactly 1 cycle later for 1 cycle.
